// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one word fetch at a time and
// buffers returned words for decode. Redirects flush the buffer and restart fetch.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
);

   localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {StFetch, StWait, StFull} state_e;

   state_e            state_q, state_d;
   logic [31:0]       fetch_pc_q, fetch_pc_d;
   logic [31:0]       stale_addr_q, stale_addr_d;
   logic [31:0]       req_pc_q, req_pc_d;
   logic              stale_q, stale_d;
   logic              started_q;
   logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]   count_q, cnt_after;
   logic [31:0]       data_q [FIFO_DEPTH];
   logic [31:0]       pc_q   [FIFO_DEPTH];
   logic              push, pop, room, req_fire;

   assign pop      = instr_valid && instr_ready;
   assign push     = (state_q == StWait) && imem_rsp_valid && !stale_q && !redirect;
   assign req_fire = imem_req_valid && imem_req_ready;

   always_comb begin
      cnt_after = count_q;
      if (push && !pop) cnt_after = count_q + CntW'(1);
      else if (pop && !push) cnt_after = count_q - CntW'(1);
   end
   assign room = cnt_after < CntW'(FIFO_DEPTH);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StFetch;
         fetch_pc_q   <= RESET_PC;
         stale_addr_q <= RESET_PC;
         req_pc_q     <= RESET_PC;
         stale_q      <= 1'b0;
         started_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         stale_addr_q <= stale_addr_d;
         req_pc_q     <= req_pc_d;
         stale_q      <= stale_d;
         started_q    <= 1'b1;
      end
   end

   // Next-state logic
   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      stale_d      = stale_q;
      stale_addr_d = stale_addr_q;
      req_pc_d     = req_pc_q;
      unique case (state_q)
         StFetch: begin
            if (req_fire) begin
               state_d  = StWait;
               req_pc_d = imem_req_addr;
               if (!stale_q && !redirect) fetch_pc_d = fetch_pc_q + 32'd4;
            end
            // The presented address must not move until accepted, so latch it.
            if (redirect) begin
               stale_d = 1'b1;
               if (!stale_q) stale_addr_d = fetch_pc_q;
            end
         end
         StWait: begin
            if (imem_rsp_valid) begin
               stale_d = 1'b0;
               state_d = (redirect || room) ? StFetch : StFull;
            end else if (redirect) begin
               stale_d = 1'b1;
            end
         end
         StFull: begin
            if (redirect || room) state_d = StFetch;
         end
         default: state_d = StFetch;
      endcase
      if (redirect) fetch_pc_d = {redirect_pc[31:2], 2'b00};
   end

   // Outputs
   always_comb begin
      imem_req_valid = (state_q == StFetch) && started_q;
      imem_req_addr  = stale_q ? stale_addr_q : fetch_pc_q;
      instr_valid    = (count_q != '0);
      instr          = data_q[rd_ptr_q];
      instr_pc       = pc_q[rd_ptr_q];
   end

   // Instruction buffer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            data_q[i] <= '0;
            pc_q[i]   <= '0;
         end
      end else if (redirect) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         count_q <= cnt_after;
         if (push) begin
            data_q[wr_ptr_q] <= imem_rsp_data;
            pc_q[wr_ptr_q]   <= req_pc_q;
            wr_ptr_q <= (wr_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= (rd_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: drives the memory side by hand and checks
// requests and buffered instructions against hand-computed values.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;
   logic        redirect;
   logic [31:0] redirect_pc;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   instr_fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_ready    (instr_ready),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One zero-wait fetch: check request, accept it, return the word next cycle.
   task automatic fetch_one(input logic [31:0] addr, input logic [31:0] word);
      check("req_valid", {31'b0, imem_req_valid}, 32'd1);
      check("req_addr", imem_req_addr, addr);
      imem_req_ready = 1'b1;
      step();
      imem_req_ready = 1'b0;
      check("wait_no_req", {31'b0, imem_req_valid}, 32'd0);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word;
      step();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
   endtask

   task automatic head(input logic [31:0] pc, input logic [31:0] word);
      check("head_valid", {31'b0, instr_valid}, 32'd1);
      check("head_pc", instr_pc, pc);
      check("head_instr", instr, word);
   endtask

   initial begin
      rst_n          = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      instr_ready    = 1'b0;
      redirect       = 1'b0;
      redirect_pc    = 32'h0;

      // Reset
      step(); step(); step();
      check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      check("rst_req_addr", imem_req_addr, 32'h0);
      check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
      check("rst_instr", instr, 32'h0);
      check("rst_instr_pc", instr_pc, 32'h0);
      rst_n = 1'b1;
      step();
      check("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
      check("first_req_addr", imem_req_addr, 32'h0);
      check("first_instr_valid", {31'b0, instr_valid}, 32'd0);

      // Zero-wait stream
      instr_ready = 1'b1;
      fetch_one(32'h0, 32'h0000_0013); head(32'h0, 32'h0000_0013);
      fetch_one(32'h4, 32'h0010_0093); head(32'h4, 32'h0010_0093);
      fetch_one(32'h8, 32'h0020_0113); head(32'h8, 32'h0020_0113);

      // Back-pressure into FULL
      step();
      check("drained", {31'b0, instr_valid}, 32'd0);
      instr_ready = 1'b0;
      fetch_one(32'hC, 32'h0030_0193);
      fetch_one(32'h10, 32'h0040_0213);
      check("full_no_req", {31'b0, imem_req_valid}, 32'd0);
      step(); step();
      check("full_still_no_req", {31'b0, imem_req_valid}, 32'd0);
      head(32'hC, 32'h0030_0193);
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      head(32'h10, 32'h0040_0213);
      check("resume_req_valid", {31'b0, imem_req_valid}, 32'd1);
      check("resume_req_addr", imem_req_addr, 32'h14);

      // Redirect during WAIT
      imem_req_ready = 1'b1;
      step();
      imem_req_ready = 1'b0;
      redirect = 1'b1; redirect_pc = 32'h103;
      step();
      redirect = 1'b0;
      check("rdw_flushed", {31'b0, instr_valid}, 32'd0);
      check("rdw_no_req", {31'b0, imem_req_valid}, 32'd0);
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
      step();
      imem_rsp_valid = 1'b0;
      check("rdw_dropped", {31'b0, instr_valid}, 32'd0);
      instr_ready = 1'b1;
      fetch_one(32'h100, 32'h0050_0293); head(32'h100, 32'h0050_0293);

      // Redirect while request pending
      step();
      check("rdf_empty", {31'b0, instr_valid}, 32'd0);
      redirect = 1'b1; redirect_pc = 32'h200;
      step();
      redirect = 1'b0;
      check("rdf_hold_valid", {31'b0, imem_req_valid}, 32'd1);
      check("rdf_hold_addr", imem_req_addr, 32'h104);
      step();
      check("rdf_hold_addr2", imem_req_addr, 32'h104);
      imem_req_ready = 1'b1;
      step();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
      step();
      imem_rsp_valid = 1'b0;
      check("rdf_dropped", {31'b0, instr_valid}, 32'd0);
      fetch_one(32'h200, 32'h0060_0313); head(32'h200, 32'h0060_0313);

      // Redirect accepted same cycle, PC wrap
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF; imem_req_ready = 1'b1;
      step();
      redirect = 1'b0; imem_req_ready = 1'b0;
      check("rda_flushed", {31'b0, instr_valid}, 32'd0);
      check("rda_wait", {31'b0, imem_req_valid}, 32'd0);
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
      step();
      imem_rsp_valid = 1'b0;
      check("rda_dropped", {31'b0, instr_valid}, 32'd0);
      instr_ready = 1'b0;
      fetch_one(32'hFFFF_FFFC, 32'h0070_0393); head(32'hFFFF_FFFC, 32'h0070_0393);
      check("wrap_addr", imem_req_addr, 32'h0);

      // Async reset mid-WAIT with one buffered entry
      imem_req_ready = 1'b1;
      step();
      imem_req_ready = 1'b0;
      check("pre_rst_valid", {31'b0, instr_valid}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_instr_valid", {31'b0, instr_valid}, 32'd0);
      check("arst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      check("arst_instr", instr, 32'h0);
      check("arst_instr_pc", instr_pc, 32'h0);
      check("arst_req_addr", imem_req_addr, 32'h0);
      step(); step();
      rst_n = 1'b1;
      check("rel_no_req_yet", {31'b0, imem_req_valid}, 32'd0);
      step();
      check("rel_req_valid", {31'b0, imem_req_valid}, 32'd1);
      check("rel_req_addr", imem_req_addr, 32'h0);
      check("rel_instr_valid", {31'b0, instr_valid}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
